// File: rtl/conv2d_sweep_ctrl_if.sv
// Engine and result-RAM bus of the convolution sweep controller.
// The controller owns the master side; the engine/RAM pair is the slave.
interface conv2d_sweep_ctrl_if #(
    parameter int ADDRA_W = 4,
    parameter int ADDRB_W = 13,
    parameter int PIX_W   = 32,
    parameter int WA_W    = 10
);
    logic               conv_en;
    logic [ADDRA_W-1:0] conv_addrA;
    logic [ADDRB_W-1:0] conv_addrB;
    logic [PIX_W-1:0]   conv_pix;
    logic               conv_done;
    logic               wr_en;
    logic [WA_W-1:0]    wr_addr;
    logic [PIX_W-1:0]   wr_data;

    modport master (
        output conv_en, conv_addrA, conv_addrB, wr_en, wr_addr, wr_data,
        input  conv_pix, conv_done
    );

    modport slave (
        input  conv_en, conv_addrA, conv_addrB, wr_en, wr_addr, wr_data,
        output conv_pix, conv_done
    );
endinterface

// File: rtl/conv2d_sweep_ctrl.sv
// Frame-level initiator for a single-pixel convolution engine: walks the
// output feature map in raster order, issues one engine request per pixel,
// and writes each returned pixel to the output RAM at its linear index.
module conv2d_sweep_ctrl #(
    parameter int IMG_W   = 28,
    parameter int OUT_W   = 26,
    parameter int OUT_H   = 26,
    parameter int ADDRA_W = 4,
    parameter int ADDRB_W = 13,
    parameter int PIX_W   = 32,
    parameter int WA_W    = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDRA_W-1:0] kernel_sel,
    output logic               busy,
    output logic               frame_done,
    conv2d_sweep_ctrl_if.master bus
);

    // Counter widths stay at least one bit wide for 1x1 output maps.
    localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;

    localparam logic [COL_W-1:0]   COL_LAST = COL_W'(OUT_W - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST = ROW_W'(OUT_H - 1);
    localparam logic [ADDRB_W-1:0] ROW_STEP = ADDRB_W'(IMG_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_REARM,
        S_FINISH
    } state_t;

    state_t state, state_nxt;

    logic [COL_W-1:0]   col, col_nxt;
    logic [ROW_W-1:0]   row, row_nxt;
    logic [ADDRB_W-1:0] row_base, row_base_nxt;
    logic [WA_W-1:0]    idx;
    logic               last_pix;

    assign last_pix = (col == COL_LAST) && (row == ROW_LAST);

    // Control outputs decode directly from the state, so reset clears them
    // asynchronously together with the state register.
    assign bus.conv_en = (state == S_ISSUE);
    assign busy        = (state != S_IDLE);
    assign frame_done  = (state == S_FINISH);

    // Raster advance: step along the row, or wrap to the next row by adding
    // the image pitch to the accumulated row base.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        col_nxt      = col + COL_W'(1);
        row_nxt      = row;
        row_base_nxt = row_base;
        if (col == COL_LAST) begin
            col_nxt      = '0;
            row_nxt      = row + ROW_W'(1);
            row_base_nxt = row_base + ROW_STEP;
        end
    end

    // Next-state logic of the issue / re-arm handshake with the engine.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (start)          state_nxt = S_ISSUE;
            S_ISSUE:  if (bus.conv_done)  state_nxt = S_REARM;
            S_REARM:  if (!bus.conv_done) state_nxt = last_pix ? S_FINISH : S_ISSUE;
            S_FINISH:                     state_nxt = S_IDLE;
            default:                      state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every flop samples pre-edge values regardless of block ordering.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Datapath: pixel counters, engine addresses and the result write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col            <= '0;
            row            <= '0;
            row_base       <= '0;
            idx            <= '0;
            bus.conv_addrA <= '0;
            bus.conv_addrB <= '0;
            bus.wr_en      <= 1'b0;
            bus.wr_addr    <= '0;
            bus.wr_data    <= '0;
        end else begin
            bus.wr_en <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    col            <= '0;
                    row            <= '0;
                    row_base       <= '0;
                    idx            <= '0;
                    bus.conv_addrB <= '0;
                    if (start) bus.conv_addrA <= kernel_sel;
                end
                S_ISSUE: begin
                    if (bus.conv_done) begin
                        bus.wr_en   <= 1'b1;
                        bus.wr_addr <= idx;
                        bus.wr_data <= bus.conv_pix;
                        idx         <= idx + WA_W'(1);
                    end
                end
                S_REARM: begin
                    // Addresses only move while the engine is disarmed, so
                    // they are stable for the whole time conv_en is high.
                    if (!bus.conv_done && !last_pix) begin
                        col            <= col_nxt;
                        row            <= row_nxt;
                        row_base       <= row_base_nxt;
                        bus.conv_addrB <= row_base_nxt + ADDRB_W'(col_nxt);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
